// File: rtl/grad_spi_sched_if.sv
// Requester, serialiser and status signals of the gradient SPI scheduler.
// slave = scheduler side, master = environment (requesters + serialiser) side.
interface grad_spi_sched_if;
    logic        en_i;
    logic [3:0]  ch_valid_i;
    logic [63:0] ch_data_i;
    logic [3:0]  ch_ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_i;
    logic        err_o;
    logic [15:0] xfer_cnt_o;
    logic        idle_o;

    modport slave (
        input  en_i, ch_valid_i, ch_data_i, busy_i,
        output ch_ready_o, data_o, valid_o, err_o, xfer_cnt_o, idle_o
    );

    modport master (
        output en_i, ch_valid_i, ch_data_i, busy_i,
        input  ch_ready_o, data_o, valid_o, err_o, xfer_cnt_o, idle_o
    );
endinterface

// File: rtl/grad_spi_sched.sv
// Round-robin scheduler packing one of four gradient DAC codes into a 32-bit SPI command word.
// Latency: grant and latch in IDLE, valid_o one cycle later in ISSUE; at least 4 cycles between words.
// Backpressure: waits for serialiser busy_i to rise then fall; a missing busy rise aborts with sticky err_o.
module grad_spi_sched #(
    parameter int BUSY_TIMEOUT = 255,
    parameter int NCH          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    grad_spi_sched_if.slave sif
);
    localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    last_grant;
    logic [1:0]    grant;
    logic [1:0]    win;
    logic          win_found;
    logic          go;
    logic          tmo_done;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   xfer_cnt;
    logic          err;
    logic [31:0]   data_q;

    // Search begins one past the last completed grant so every requester gets a turn.
    always_comb begin : p_rr
        logic [1:0] cand;
        cand      = '0;
        win       = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            cand = last_grant + 2'(i);
            if (!win_found && sif.ch_valid_i[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    // rst_n keeps the combinational accept strobe quiet while reset is held.
    assign go       = rst_n && (state == IDLE) && sif.en_i && !err && win_found;
    assign tmo_done = (tmo_cnt == TW'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        sif.ch_ready_o = '0;
        sif.valid_o    = 1'b0;
        sif.idle_o     = 1'b0;
        case (state)
            IDLE: begin
                sif.idle_o = 1'b1;
                if (go) begin
                    state_nxt           = ISSUE;
                    sif.ch_ready_o[win] = 1'b1;
                end
            end
            ISSUE: begin
                sif.valid_o = 1'b1;
                state_nxt   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (sif.busy_i)
                    state_nxt = WAIT_DONE;
                else if (tmo_done)
                    state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (!sif.busy_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            grant      <= 2'd0;
            data_q     <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (go) begin
                grant  <= win;
                data_q <= {5'b0, win, 1'b0, 8'h00, sif.ch_data_i[{win, 4'b0000} +: 16]};
            end
            if (state == WAIT_BUSY && !sif.busy_i && !tmo_done)
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;
            if (state == WAIT_BUSY && !sif.busy_i && tmo_done)
                err <= 1'b1;
            // Only a completed transfer advances the round-robin pointer.
            if (state == WAIT_DONE && !sif.busy_i) begin
                xfer_cnt   <= xfer_cnt + 16'd1;
                last_grant <= grant;
            end
        end
    end

    assign sif.data_o     = data_q;
    assign sif.err_o      = err;
    assign sif.xfer_cnt_o = xfer_cnt;
endmodule

// File: doc/grad_spi_sched.md
GRAD_SPI_SCHED -- requirements
Module: grad_spi_sched

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 255, meaning max cycles in WAIT_BUSY before abort.
REQ-002 SHALL have parameter NCH, default 4, meaning number of gradient channel requesters (fixed 4 in this revision).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en_i  input  1  scheduler enable.
REQ-006 SHALL have port ch_valid_i  input  4  per-channel update request, bit n = channel n.
REQ-007 SHALL have port ch_data_i  input  64  per-channel 16-bit DAC codes, channel n at [16n+15:16n].
REQ-008 SHALL have port ch_ready_o  output  4  per-channel accept strobe, one-hot, one cycle.
REQ-009 SHALL have port data_o  output  32  word to SPI serialiser.
REQ-010 SHALL have port valid_o  output  1  one-cycle transfer request to serialiser.
REQ-011 SHALL have port busy_i  input  1  serialiser busy flag.
REQ-012 SHALL have port err_o  output  1  sticky timeout error.
REQ-013 SHALL have port xfer_cnt_o  output  16  count of completed transfers.
REQ-014 SHALL have port idle_o  output  1  high only in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE -> ISSUE SHALL occur when en_i=1, err_o=0 and any ch_valid_i bit set; otherwise remain IDLE.
REQ-017 SHALL select the winner by round-robin: search starts at channel (last_grant+1) mod 4; last_grant resets to 3, so channel 0 wins first.
REQ-018 On the IDLE->ISSUE edge SHALL latch the winner index and its 16-bit code, and pulse the winner's ch_ready_o bit in that same cycle.
REQ-019 Requester handshake: data accepted on ch_valid_i[n]=1 and ch_ready_o[n]=1; requester drops or advances its request the following cycle.
REQ-020 In ISSUE (exactly one cycle) SHALL drive valid_o=1 with data_o[15:0]=code, [23:16]=0, [24]=0 (no broadcast), [26:25]=channel, [31:27]=0, then go to WAIT_BUSY.
REQ-021 data_o SHALL hold its value from ISSUE until the next ISSUE.
REQ-022 WAIT_BUSY: on busy_i=1 -> WAIT_DONE; timeout counter counts cycles in WAIT_BUSY; on reaching BUSY_TIMEOUT without busy_i -> set err_o, go IDLE, xfer_cnt_o unchanged.
REQ-023 WAIT_DONE: on busy_i=0 -> increment xfer_cnt_o (16-bit wrap, 0xFFFF->0x0000), update last_grant, go IDLE.
REQ-024 Minimum spacing between valid_o pulses SHALL be 4 cycles (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE each at least one cycle).
REQ-025 en_i deassert SHALL only block IDLE->ISSUE; an in-flight transfer completes normally.
REQ-026 err_o SHALL clear only by reset; while set no new transfers are issued and ch_ready_o stays 0.
REQ-027 ch_valid_i changes while not in IDLE SHALL be ignored until the next IDLE evaluation.
REQ-028 busy_i=1 already in IDLE SHALL not prevent issuing; WAIT_BUSY exits on the first busy_i=1 sample.

Reset
REQ-029 While rst_n=0: state=IDLE, ch_ready_o=0, valid_o=0, data_o=0, err_o=0, xfer_cnt_o=0, idle_o=1, last_grant=3, timeout counter=0.
REQ-030 Reset mid-transfer SHALL abort immediately without a further valid_o; the first transfer after release follows REQ-016/017.

Verification
REQ-031 Single request: ch_valid_i=4'b0100, ch_data_i[47:32]=16'h1234, serialiser model busy for 30 cycles -> one ch_ready_o=4'b0100, one valid_o with data_o=32'h0400_1234, xfer_cnt_o=1.
REQ-032 All four channels held valid -> grant order 0,1,2,3,0; data_o[26:25] = 0,1,2,3,0; xfer_cnt_o=5 after five transfers.
REQ-033 busy_i stuck at 0 -> err_o=1 exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY; further requests give no ch_ready_o and no valid_o.
REQ-034 en_i dropped during WAIT_DONE -> transfer completes, xfer_cnt_o increments, and no new ISSUE while en_i=0.
REQ-035 rst_n pulsed low in WAIT_BUSY -> all outputs at reset values asynchronously; with ch_valid_i=4'b1111 after release, channel 0 is granted first.
REQ-036 Preload xfer_cnt_o to 0xFFFF via 65535 fast-model transfers, then one more -> xfer_cnt_o=0x0000, err_o=0.
